nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder that processes 4 bits per clock through one 4-bit ripple-carry slice.
- Carry is registered between cycles, so a wide add is built from the same 4-bit adder datapath.
- Sits directly upstream of the 4-bit ripple-carry adder: it feeds that adder A/B nibbles plus a registered carry, and consumes its sum nibble and carry-out.
- Operands are accepted with a start pulse; completion is signalled with a one-cycle done pulse.

---
 rtl/nsa_pkg.sv | 17 +
 rtl/nsa_rca4.sv | 25 ++
 rtl/nibble_serial_adder.sv | 109 ++++++++++
 tb/tb_nibble_serial_adder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  // The counter must hold 0..N without wrapping, where N = width/NIBBLE
  function automatic int cnt_width(input int width);
    return $clog2(width / NIBBLE + 1);
  endfunction

endpackage

// File: rtl/nsa_rca4.sv
// Combinational 4-bit ripple-carry slice; c3 exposes the carry into bit 3.
module nsa_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic cy;

  always_comb begin
    cy = ci;
    c3 = 1'b0;
    s  = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) c3 = cy;
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles.
// Define NSA_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       s;
  logic             co, c3;
  logic             last;

  nsa_rca4 u_rca4 (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry),
    .s  (s),
    .co (co),
    .c3 (c3)
  );

  assign last = (state == RUN) && (cnt == CW'(N - 1));
  // Sum nibbles enter at the MSB end so after N shifts nibble 0 sits at the bottom
  assign res_nxt = (res >> NIBBLE) | (WIDTH'(s) << (WIDTH - NIBBLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          res   <= res_nxt;
          carry <= co;
          a_sh  <= a_sh >> NIBBLE;
          b_sh  <= b_sh >> NIBBLE;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum  <= res_nxt;
            cout <= co;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NSA_SIGNED_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= c3 ^ co;
  end
`else
  logic unused_c3;
  assign unused_c3 = c3;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        start4, cin4, busy4, done4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef NSA_SIGNED_OVF_EN
  logic        ovf16, ovf4;
`endif

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef NSA_SIGNED_OVF_EN
    , .ovf(ovf16)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef NSA_SIGNED_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] es, input logic ec);
    int lat;
    @(negedge clk);
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    chk({tag, "_busy"}, 32'(busy16), 32'd1);
    lat = 0;
    while (!done16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum16), 32'(es));
    chk({tag, "_cout"}, 32'(cout16), 32'(ec));
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(done16), 32'd0);
    chk({tag, "_idle"}, 32'(busy16), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_held;
    int lat4;
    rst_n = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #1;
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_sum", 32'(sum16), 32'd0);
    chk("rst_cout", 32'(cout16), 32'd0);
`ifdef NSA_SIGNED_OVF_EN
    chk("rst_ovf", 32'(ovf16), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    add16("zero_ffff", 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0);
    add16("ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
    add16("ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // start held high: accepts at edges 0,6,12; done after edges 4,10,16
    exp_held = 16'h0000;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      start16 = 1'b1;
      a16 = 16'(cyc * 'h111);
      b16 = 16'h1000 + 16'(cyc);
      cin16 = 1'b0;
      @(posedge clk); #1;
      if (cyc == 4)  exp_held = 16'h1000;
      if (cyc == 10) exp_held = 16'h166C;
      if (cyc == 16) exp_held = 16'h1CD8;
      chk("b2b_done", 32'(done16), 32'(cyc == 4 || cyc == 10 || cyc == 16));
      chk("b2b_sum", 32'(sum16), 32'(exp_held));
    end
    @(negedge clk) start16 = 1'b0;
    repeat (3) @(posedge clk);

`ifdef NSA_SIGNED_OVF_EN
    add16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    chk("ovf_pos_ovf", 32'(ovf16), 32'd1);
    add16("ovf_neg", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    chk("ovf_neg_ovf", 32'(ovf16), 32'd0);
    add16("ovf_set", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`endif

    // abort an add in flight; the previous nonzero result must clear
    @(negedge clk);
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_sum", 32'(sum16), 32'd0);
    chk("abort_cout", 32'(cout16), 32'd0);
`ifdef NSA_SIGNED_OVF_EN
    chk("abort_ovf", 32'(ovf16), 32'd0);
`endif
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_nodone", 32'(done16), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_nodone", 32'(done16 | busy16), 32'd0);
    end
    add16("after_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);

    // single-nibble instance: done one cycle after the accept edge
    @(negedge clk);
    a4 = 4'hA; b4 = 4'hF; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat4 = 0;
    while (!done4 && lat4 < 20) begin
      @(posedge clk); #1;
      lat4++;
    end
    chk("w4_lat", 32'(lat4), 32'd1);
    chk("w4_sum", 32'(sum4), 32'h9);
    chk("w4_cout", 32'(cout4), 32'd1);
    @(posedge clk); #1;
    chk("w4_idle", 32'(busy4 | done4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
